// File: rtl/data_mem_controller_if.sv
// data_mem_controller_if
// Bundles the consumer-side (LSU) request/response signals and the
// channel-side external data-memory signals of the data memory controller.
//   master : controller view. Drives mem_* requests and consumer responses,
//            samples consumer requests and memory completions.
//   slave  : environment view (LSUs plus external memory).
// Multi-port fields are packed as [port][bits].
interface data_mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);
  // Consumer (LSU) side
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  // External memory channel side
  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/data_mem_controller.sv
// data_mem_controller
// Arbitrates per-thread LSU load/store requests onto NUM_CHANNELS external
// data-memory channels. Each channel owns one consumer at a time, forwards
// its request to memory, then relays the completion back over a four-phase
// valid/ready handshake.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high; aborts all in-flight transactions
//   bus   : data_mem_controller_if.master (consumer and memory signals)
// Parameters: ADDR_BITS, DATA_BITS, NUM_CONSUMERS, NUM_CHANNELS,
//   WRITE_ENABLE (0 removes all write behaviour; write outputs stay 0).
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_controller_if.master bus
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                                  state_q [NUM_CHANNELS];
  state_t                                  state_d [NUM_CHANNELS];
  logic [IDX_W-1:0]                        cur_q   [NUM_CHANNELS];
  logic [IDX_W-1:0]                        cur_d   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]                serving_q, serving_d;

  logic [NUM_CHANNELS-1:0]                 mem_rd_vld_q,  mem_rd_vld_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_rd_addr_q, mem_rd_addr_d;
  logic [NUM_CHANNELS-1:0]                 mem_wr_vld_q,  mem_wr_vld_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_wr_data_q, mem_wr_data_d;

  logic [NUM_CONSUMERS-1:0]                cons_rd_rdy_q,  cons_rd_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_rd_data_q, cons_rd_data_d;
  logic [NUM_CONSUMERS-1:0]                cons_wr_rdy_q,  cons_wr_rdy_d;

  // Write requests are masked out entirely when writes are disabled, so the
  // write states can never be entered.
  logic [NUM_CONSUMERS-1:0]                wr_req;
  // Consumers already owned, or claimed earlier in this cycle by a
  // lower-indexed channel.
  logic [NUM_CONSUMERS-1:0]                claimed;
  logic                                    found;

  assign wr_req = WRITE_ENABLE ? bus.consumer_write_valid : '0;

  // Next-state / output logic: channels are evaluated in index order so a
  // lower channel's claim hides that consumer from higher channels.
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    serving_d      = serving_q;
    mem_rd_vld_d   = mem_rd_vld_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_vld_d   = mem_wr_vld_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    cons_rd_rdy_d  = cons_rd_rdy_q;
    cons_rd_data_d = cons_rd_data_q;
    cons_wr_rdy_d  = cons_wr_rdy_q;
    claimed        = serving_q;
    found          = 1'b0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      case (state_q[c])
        IDLE: begin
          for (int j = 0; j < NUM_CONSUMERS; j++) begin
            if (!found && !claimed[j] && (bus.consumer_read_valid[j] || wr_req[j])) begin
              found        = 1'b1;
              claimed[j]   = 1'b1;
              serving_d[j] = 1'b1;
              cur_d[c]     = IDX_W'(j);
              // Read takes priority when a consumer raises both.
              if (bus.consumer_read_valid[j]) begin
                mem_rd_vld_d[c]  = 1'b1;
                mem_rd_addr_d[c] = bus.consumer_read_address[j];
                state_d[c]       = READ_WAITING;
              end else begin
                mem_wr_vld_d[c]  = 1'b1;
                mem_wr_addr_d[c] = bus.consumer_write_address[j];
                mem_wr_data_d[c] = bus.consumer_write_data[j];
                state_d[c]       = WRITE_WAITING;
              end
            end
          end
        end
        READ_WAITING: begin
          if (bus.mem_read_ready[c]) begin
            mem_rd_vld_d[c]              = 1'b0;
            cons_rd_data_d[cur_q[c]]     = bus.mem_read_data[c];
            cons_rd_rdy_d[cur_q[c]]      = 1'b1;
            state_d[c]                   = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (bus.mem_write_ready[c]) begin
            mem_wr_vld_d[c]              = 1'b0;
            cons_wr_rdy_d[cur_q[c]]      = 1'b1;
            state_d[c]                   = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!bus.consumer_read_valid[cur_q[c]]) begin
            cons_rd_rdy_d[cur_q[c]]      = 1'b0;
            serving_d[cur_q[c]]          = 1'b0;
            state_d[c]                   = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!wr_req[cur_q[c]]) begin
            cons_wr_rdy_d[cur_q[c]]      = 1'b0;
            serving_d[cur_q[c]]          = 1'b0;
            state_d[c]                   = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // State and registered outputs; reset clears data outputs as well so the
  // bus is fully quiet after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cur_q[c]   <= '0;
      end
      serving_q      <= '0;
      mem_rd_vld_q   <= '0;
      mem_rd_addr_q  <= '0;
      mem_wr_vld_q   <= '0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      cons_rd_rdy_q  <= '0;
      cons_rd_data_q <= '0;
      cons_wr_rdy_q  <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      serving_q      <= serving_d;
      mem_rd_vld_q   <= mem_rd_vld_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_vld_q   <= mem_wr_vld_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      cons_rd_rdy_q  <= cons_rd_rdy_d;
      cons_rd_data_q <= cons_rd_data_d;
      cons_wr_rdy_q  <= cons_wr_rdy_d;
    end
  end

  assign bus.mem_read_valid       = mem_rd_vld_q;
  assign bus.mem_read_address     = mem_rd_addr_q;
  assign bus.mem_write_valid      = mem_wr_vld_q;
  assign bus.mem_write_address    = mem_wr_addr_q;
  assign bus.mem_write_data       = mem_wr_data_q;
  assign bus.consumer_read_ready  = cons_rd_rdy_q;
  assign bus.consumer_read_data   = cons_rd_data_q;
  assign bus.consumer_write_ready = cons_wr_rdy_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller
// Bench for data_mem_controller. Main instance: 2 channels, writes enabled,
// exercised with directed cases and randomized per-consumer traffic checked by
// a response scoreboard against a reference memory. Second instance:
// 1 channel, writes disabled, for strict-order contention and write masking.
module tb_data_mem_controller;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NC  = 4;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_controller_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) bus ();
  data_mem_controller_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1))   bus1 ();

  data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH),
                        .WRITE_ENABLE(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                        .WRITE_ENABLE(1'b0)) u_dut_nowr (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed { logic wr; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q [NC][$];
  logic [DW-1:0] ref_mem [256];   // what memory must hold, by request order
  logic [DW-1:0] ext_mem [256];   // the simulated external memory
  int            fixed_wait = 0;  // <0 selects random memory latency 0..3

  // ---------------- external memory model, main instance ----------------
  bit rd_busy [NCH];
  bit wr_busy [NCH];
  int rd_cnt [NCH], rd_tgt [NCH], wr_cnt [NCH], wr_tgt [NCH];

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.mem_read_ready[c]) bus.mem_read_ready[c] = 1'b0;
      else if (bus.mem_read_valid[c]) begin
        if (!rd_busy[c]) begin
          rd_busy[c] = 1'b1;
          rd_cnt[c]  = 0;
          rd_tgt[c]  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (rd_cnt[c] == rd_tgt[c]) begin
          bus.mem_read_ready[c] = 1'b1;
          bus.mem_read_data[c]  = ext_mem[bus.mem_read_address[c]];
          rd_busy[c] = 1'b0;
        end else rd_cnt[c]++;
      end else rd_busy[c] = 1'b0;

      if (bus.mem_write_ready[c]) bus.mem_write_ready[c] = 1'b0;
      else if (bus.mem_write_valid[c]) begin
        if (!wr_busy[c]) begin
          wr_busy[c] = 1'b1;
          wr_cnt[c]  = 0;
          wr_tgt[c]  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wr_cnt[c] == wr_tgt[c]) begin
          bus.mem_write_ready[c] = 1'b1;
          ext_mem[bus.mem_write_address[c]] = bus.mem_write_data[c];
          wr_busy[c] = 1'b0;
        end else wr_cnt[c]++;
      end else wr_busy[c] = 1'b0;
    end
  end

  // ---------------- memory model, no-write instance (zero wait) ----------------
  always @(negedge clk) begin
    if (bus1.mem_read_ready[0]) bus1.mem_read_ready[0] = 1'b0;
    else if (bus1.mem_read_valid[0]) begin
      bus1.mem_read_ready[0] = 1'b1;
      bus1.mem_read_data[0]  = bus1.mem_read_address[0] ^ 8'hA5;
    end
  end

  // ---------------- response monitor ----------------
  logic [NC-1:0] prev_rr = '0;
  logic [NC-1:0] prev_wr = '0;
  exp_t          mon_e;
  logic [AW-1:0] ch_addr0, ch_addr1;

  always @(negedge clk) begin
    for (int j = 0; j < NC; j++) begin
      if ((bus.consumer_read_ready[j] && !prev_rr[j]) || (bus.consumer_write_ready[j] && !prev_wr[j])) begin
        if (exp_q[j].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_resp: consumer %0d got a response, required none pending", j);
        end else begin
          mon_e = exp_q[j].pop_front();
          check("sb_resp_kind", 32'(bus.consumer_write_ready[j]), 32'(mon_e.wr));
          if (!mon_e.wr) check("sb_read_data", 32'(bus.consumer_read_data[j]), 32'(mon_e.data));
        end
      end
    end
    prev_rr = bus.consumer_read_ready;
    prev_wr = bus.consumer_write_ready;
    for (int c = 0; c < NCH; c++)
      if (bus.mem_read_valid[c] || bus.mem_write_valid[c])
        check("chan_rd_wr_excl", 32'(bus.mem_read_valid[c] & bus.mem_write_valid[c]), 32'd0);
    // Addresses carry the owning consumer in bits [7:6] whenever both
    // channels are busy, so equal tags mean one consumer held twice.
    if ((bus.mem_read_valid[0] || bus.mem_write_valid[0]) &&
        (bus.mem_read_valid[1] || bus.mem_write_valid[1])) begin
      ch_addr0 = bus.mem_read_valid[0] ? bus.mem_read_address[0] : bus.mem_write_address[0];
      ch_addr1 = bus.mem_read_valid[1] ? bus.mem_read_address[1] : bus.mem_write_address[1];
      check("consumer_on_two_channels", 32'(ch_addr0[7:6] != ch_addr1[7:6]), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_rdy(input int j, input bit wr, input bit level, input string name);
    int cnt = 0;
    while (((wr ? bus.consumer_write_ready[j] : bus.consumer_read_ready[j]) != level) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check(name, 32'(cnt < 200), 32'd1);
  endtask

  task automatic consumer_run(input int j, input int nops);
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
    int            gap;
    for (int k = 0; k < nops; k++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = {2'(j), 6'($urandom)};
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      e.wr = wr;
      if (wr) begin
        ref_mem[a] = d;
        e.data     = d;
        bus.consumer_write_address[j] = a;
        bus.consumer_write_data[j]    = d;
        bus.consumer_write_valid[j]   = 1'b1;
      end else begin
        e.data = ref_mem[a];
        bus.consumer_read_address[j] = a;
        bus.consumer_read_valid[j]   = 1'b1;
      end
      exp_q[j].push_back(e);
      wait_rdy(j, wr, 1'b1, "rand_ready_rise");
      if (wr) bus.consumer_write_valid[j] = 1'b0;
      else    bus.consumer_read_valid[j]  = 1'b0;
      wait_rdy(j, wr, 1'b0, "rand_ready_fall");
    end
  endtask

  task automatic push_exp(input int j, input bit wr, input logic [DW-1:0] d);
    exp_t e;
    e.wr   = wr;
    e.data = d;
    exp_q[j].push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int      order [3];
  int      n_served;
  bit      saw_wr;
  bit      read1_done;
  int      cnt;

  initial begin
    bus.consumer_read_valid = '0;  bus.consumer_read_address = '0;
    bus.consumer_write_valid = '0; bus.consumer_write_address = '0; bus.consumer_write_data = '0;
    bus.mem_read_ready = '0; bus.mem_read_data = '0; bus.mem_write_ready = '0;
    bus1.consumer_read_valid = '0;  bus1.consumer_read_address = '0;
    bus1.consumer_write_valid = '0; bus1.consumer_write_address = '0; bus1.consumer_write_data = '0;
    bus1.mem_read_ready = '0; bus1.mem_read_data = '0; bus1.mem_write_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      ext_mem[a] = 8'($urandom);
      ref_mem[a] = ext_mem[a];
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_read_valid",  32'(bus.mem_read_valid), 32'd0);
    check("rst_mem_write_valid", 32'(bus.mem_write_valid), 32'd0);
    check("rst_cons_rd_ready",   32'(bus.consumer_read_ready), 32'd0);
    check("rst_cons_wr_ready",   32'(bus.consumer_write_ready), 32'd0);
    check("rst_mem_rd_addr",     32'(bus.mem_read_address), 32'd0);
    check("rst_mem_wr_addr",     32'(bus.mem_write_address), 32'd0);
    check("rst_mem_wr_data",     32'(bus.mem_write_data), 32'd0);
    check("rst_cons_rd_data",    32'(bus.consumer_read_data), 32'd0);
    check("rst_nowr_rd_valid",   32'(bus1.mem_read_valid), 32'd0);
    reset = 1'b0;

    // Single read, memory answers after 3 wait cycles
    fixed_wait = 3;
    ext_mem[8'h10] = 8'h5A;
    ref_mem[8'h10] = 8'h5A;
    @(negedge clk);
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2]   = 1'b1;
    push_exp(2, 1'b0, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t1_mem_read_valid", 32'(bus.mem_read_valid), 32'b01);
      check("t1_mem_read_addr",  32'(bus.mem_read_address[0]), 32'h10);
      check("t1_ready_early",    32'(bus.consumer_read_ready[2]), 32'd0);
    end
    @(negedge clk);
    check("t1_mem_valid_drop", 32'(bus.mem_read_valid), 32'd0);
    check("t1_ready_c5",       32'(bus.consumer_read_ready), 32'b0100);
    check("t1_data_c5",        32'(bus.consumer_read_data[2]), 32'h5A);
    @(negedge clk);
    check("t1_ready_hold",     32'(bus.consumer_read_ready[2]), 32'd1);
    bus.consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    check("t1_ready_fall",     32'(bus.consumer_read_ready[2]), 32'd0);
    check("t1_data_held",      32'(bus.consumer_read_data[2]), 32'h5A);

    // Two consumers claimed by two channels in the same cycle
    fixed_wait = 0;
    @(negedge clk);
    bus.consumer_read_address[1] = 8'h41;
    bus.consumer_read_address[2] = 8'h82;
    bus.consumer_read_valid[1]   = 1'b1;
    bus.consumer_read_valid[2]   = 1'b1;
    push_exp(1, 1'b0, ref_mem[8'h41]);
    push_exp(2, 1'b0, ref_mem[8'h82]);
    @(negedge clk);
    check("t2_both_valid", 32'(bus.mem_read_valid), 32'b11);
    check("t2_ch0_addr",   32'(bus.mem_read_address[0]), 32'h41);
    check("t2_ch1_addr",   32'(bus.mem_read_address[1]), 32'h82);
    @(negedge clk);
    check("t2_both_ready", 32'(bus.consumer_read_ready), 32'b0110);
    bus.consumer_read_valid[1] = 1'b0;
    bus.consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    check("t2_ready_fall", 32'(bus.consumer_read_ready), 32'd0);

    // Write 0xC3 to 0x22 from consumer 0
    @(negedge clk);
    bus.consumer_write_address[0] = 8'h22;
    bus.consumer_write_data[0]    = 8'hC3;
    bus.consumer_write_valid[0]   = 1'b1;
    ref_mem[8'h22] = 8'hC3;
    push_exp(0, 1'b1, 8'hC3);
    @(negedge clk);
    check("t3_mem_write_valid", 32'(bus.mem_write_valid), 32'b01);
    check("t3_mem_write_addr",  32'(bus.mem_write_address[0]), 32'h22);
    check("t3_mem_write_data",  32'(bus.mem_write_data[0]), 32'hC3);
    @(negedge clk);
    check("t3_write_ready",     32'(bus.consumer_write_ready), 32'b0001);
    @(negedge clk);
    check("t3_write_ready_hold", 32'(bus.consumer_write_ready[0]), 32'd1);
    bus.consumer_write_valid[0] = 1'b0;
    @(negedge clk);
    check("t3_write_ready_fall", 32'(bus.consumer_write_ready[0]), 32'd0);
    check("t3_mem_content",      32'(ext_mem[8'h22]), 32'hC3);

    // Reset while a read is waiting on memory; the held request completes afterwards
    fixed_wait = 3;
    @(negedge clk);
    bus.consumer_read_address[3] = 8'hF0;
    bus.consumer_read_valid[3]   = 1'b1;
    push_exp(3, 1'b0, ref_mem[8'hF0]);
    @(negedge clk);
    check("t4_claim", 32'(bus.mem_read_valid), 32'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_mem_valid",  32'(bus.mem_read_valid), 32'd0);
    check("t4_rst_mem_addr",   32'(bus.mem_read_address), 32'd0);
    check("t4_rst_ready",      32'(bus.consumer_read_ready), 32'd0);
    check("t4_rst_rd_data",    32'(bus.consumer_read_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t4_reclaim",        32'(bus.mem_read_valid), 32'b01);
    check("t4_reclaim_addr",   32'(bus.mem_read_address[0]), 32'hF0);
    wait_rdy(3, 1'b0, 1'b1, "t4_ready_rise");
    bus.consumer_read_valid[3] = 1'b0;
    wait_rdy(3, 1'b0, 1'b0, "t4_ready_fall");

    // Randomized traffic from all consumers with random memory latency
    fixed_wait = -1;
    fork
      consumer_run(0, 25);
      consumer_run(1, 25);
      consumer_run(2, 25);
      consumer_run(3, 25);
    join
    repeat (4) @(negedge clk);
    for (int j = 0; j < NC; j++) check("sb_queue_drained", 32'(exp_q[j].size()), 32'd0);
    for (int a = 0; a < 256; a++) check("mem_dump", 32'(ext_mem[a]), 32'(ref_mem[a]));

    // Single channel contention: consumers 0,1,3 must be served in that order
    @(negedge clk);
    bus1.consumer_read_address[0] = 8'h01;
    bus1.consumer_read_address[1] = 8'h02;
    bus1.consumer_read_address[3] = 8'h03;
    bus1.consumer_read_valid = 4'b1011;
    n_served = 0;
    cnt = 0;
    while (n_served < 3 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      check("t5_one_ready", 32'($countones(bus1.consumer_read_ready) <= 1), 32'd1);
      for (int j = 0; j < NC; j++) begin
        if (bus1.consumer_read_valid[j] && bus1.consumer_read_ready[j]) begin
          if (n_served < 3) order[n_served] = j;
          n_served++;
          check("t5_data", 32'(bus1.consumer_read_data[j]), 32'(bus1.consumer_read_address[j] ^ 8'hA5));
          bus1.consumer_read_valid[j] = 1'b0;
        end
      end
    end
    check("t5_served_count", 32'(n_served), 32'd3);
    check("t5_order0", 32'(order[0]), 32'd0);
    check("t5_order1", 32'(order[1]), 32'd1);
    check("t5_order2", 32'(order[2]), 32'd3);
    repeat (3) @(negedge clk);

    // Writes disabled: write request ignored, concurrent read still served
    bus1.consumer_write_address[0] = 8'h55;
    bus1.consumer_write_data[0]    = 8'h99;
    bus1.consumer_write_valid[0]   = 1'b1;
    bus1.consumer_read_address[1]  = 8'h07;
    bus1.consumer_read_valid[1]    = 1'b1;
    saw_wr     = 1'b0;
    read1_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.mem_write_valid != 0 || bus1.consumer_write_ready != 0 ||
          bus1.mem_write_address != 0 || bus1.mem_write_data != 0) saw_wr = 1'b1;
      if (bus1.consumer_read_valid[1] && bus1.consumer_read_ready[1]) begin
        read1_done = 1'b1;
        check("t6_read_data", 32'(bus1.consumer_read_data[1]), 32'(8'h07 ^ 8'hA5));
        bus1.consumer_read_valid[1] = 1'b0;
      end
    end
    bus1.consumer_write_valid[0] = 1'b0;
    check("t6_no_write_activity", 32'(saw_wr), 32'd0);
    check("t6_read_served",       32'(read1_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
